// File: rtl/fifo_pop_ctrl.sv
// Read-side FIFO controller: pops the FIFO head into a 2-entry skid buffer and
// presents the words in order on a valid/ready stream at up to one word per cycle.
module fifo_pop_ctrl #(
    parameter int bits  = 32,
    parameter int cnt_w = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [bits-1:0]  fifo_dout,
    input  logic             fifo_pndng,
    output logic             fifo_pop,
    output logic [bits-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [cnt_w-1:0] pop_count,
    output logic             idle
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state_q;
    logic [bits-1:0]  e0_q;
    logic [bits-1:0]  e1_q;
    logic [cnt_w-1:0] cnt_q;
    logic [cnt_w-1:0] cnt_d;
    logic             fire;

    // Popping stops only when both entries are full, so pops never wait on out_ready.
    assign fifo_pop  = en & fifo_pndng & (state_q != S_TWO) & ~rst;
    assign fire      = out_valid & out_ready;
    assign cnt_d     = cnt_q + {{(cnt_w-1){1'b0}}, 1'b1};

    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = e0_q;
    assign pop_count = cnt_q;
    assign idle      = (state_q == S_EMPTY) & ~fifo_pndng;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            e0_q    <= '0;
            e1_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (fifo_pop) begin
                cnt_q <= cnt_d;
            end
            case (state_q)
                S_EMPTY: begin
                    if (fifo_pop) begin
                        e0_q    <= fifo_dout;
                        state_q <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (fifo_pop && fire) begin
                        e0_q <= fifo_dout;
                    end else if (fifo_pop) begin
                        e1_q    <= fifo_dout;
                        state_q <= S_TWO;
                    end else if (fire) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (fire) begin
                        e0_q    <= e1_q;
                        state_q <= S_ONE;
                    end
                end
                default: begin
                    state_q <= S_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Directed bench for fifo_pop_ctrl: a simple array-backed FIFO model feeds the
// DUT; per-cycle vector tables plus hand-written reset, wrap and empty sequences.
module tb_fifo_pop_ctrl;

    localparam int BITS  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [BITS-1:0]  fifo_dout;
    logic             fifo_pndng;
    logic             fifo_pop;
    logic [BITS-1:0]  out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] pop_count;
    logic             idle;

    fifo_pop_ctrl #(.bits(BITS), .cnt_w(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_dout  (fifo_dout),
        .fifo_pndng (fifo_pndng),
        .fifo_pop   (fifo_pop),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pop_count  (pop_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    // FIFO model: words written by the stimulus, head index advanced on pops.
    logic [BITS-1:0] mem [0:63];
    int wr = 0;
    int rd = 0;
    always @(posedge clk) if (fifo_pop) rd <= rd + 1;
    assign fifo_pndng = (rd < wr);
    assign fifo_dout  = (rd < wr) ? mem[rd[5:0]] : '0;

    typedef struct packed {
        logic             en;
        logic             rdy;
        logic             pop;
        logic             valid;
        logic             chk_data;
        logic [BITS-1:0]  data;
        logic [CNT_W-1:0] cnt;
        logic             idle;
    } vec_t;

    vec_t vecs [0:22];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic ok, input string detail);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    task automatic push_word(input logic [BITS-1:0] w);
        mem[wr[5:0]] = w;
        wr++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_range(input string name, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            logic ok;
            @(negedge clk);
            en = vecs[i].en;
            out_ready = vecs[i].rdy;
            #1;
            ok = (fifo_pop == vecs[i].pop) && (out_valid == vecs[i].valid) &&
                 (!vecs[i].chk_data || out_data == vecs[i].data) &&
                 (pop_count == vecs[i].cnt) && (idle == vecs[i].idle);
            check($sformatf("%s[%0d]", name, i - lo), ok,
                  $sformatf("got pop=%b valid=%b data=%h cnt=%0d idle=%b, want pop=%b valid=%b data=%h cnt=%0d idle=%b",
                            fifo_pop, out_valid, out_data, pop_count, idle,
                            vecs[i].pop, vecs[i].valid, vecs[i].data, vecs[i].cnt, vecs[i].idle));
            $display("vec %s[%0d] en=%b rdy=%b pop=%b valid=%b data=%h cnt=%0d idle=%b",
                     name, i - lo, en, out_ready, fifo_pop, out_valid, out_data, pop_count, idle);
        end
    endtask

    initial begin
        int k;
        int rd_snap;
        logic [BITS-1:0] first_word;
        logic got_first;

        //           en    rdy   pop   valid chk   data    cnt  idle
        // stream A,B,C with ready high
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  4'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA,  4'd1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hB,  4'd2, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC,  4'd3, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  4'd3, 1'b1};
        // backpressure with 5 words queued
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  4'd0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1,  4'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1,  4'd2, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1,  4'd2, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1,  4'd2, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2,  4'd2, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3,  4'd3, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4,  4'd4, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5,  4'd5, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  4'd5, 1'b1};
        // enable gating: fill two entries, drop en, drain, re-enable
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  4'd0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 4'd1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 4'd2, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12, 4'd2, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  4'd2, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h13, 4'd3, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h14, 4'd4, 1'b0};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  4'd4, 1'b1};

        // reset state
        @(negedge clk);
        #1;
        check("reset_state", !out_valid && !fifo_pop && out_data == '0 && pop_count == '0 && idle,
              $sformatf("got valid=%b pop=%b data=%h cnt=%0d idle=%b, want 0 0 0 0 1",
                        out_valid, fifo_pop, out_data, pop_count, idle));

        do_reset();
        push_word(32'hA); push_word(32'hB); push_word(32'hC);
        run_range("stream", 0, 4);

        do_reset();
        for (int i = 1; i <= 5; i++) push_word(BITS'(i));
        run_range("backpressure", 5, 14);

        do_reset();
        for (int i = 1; i <= 4; i++) push_word(BITS'(32'h10 + i));
        run_range("gating", 15, 22);

        // empty FIFO for 20 cycles
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("empty[%0d]", i), !fifo_pop && !out_valid && idle,
                  $sformatf("got pop=%b valid=%b idle=%b, want 0 0 1", fifo_pop, out_valid, idle));
        end

        // counter wrap: 18 words through a 4-bit counter
        do_reset();
        for (int i = 0; i < 18; i++) push_word(BITS'(32'h100 + i));
        en = 1'b1;
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 60 && !(k == 18 && idle); c++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                check($sformatf("wrap_word[%0d]", k), out_data == BITS'(32'h100 + k),
                      $sformatf("got %h, want %h", out_data, 32'h100 + k));
                $display("wrap word %0d data=%h cnt=%0d", k, out_data, pop_count);
                k++;
            end
        end
        check("wrap_words", k == 18, $sformatf("got %0d words, want 18", k));
        check("wrap_count", pop_count == 4'd2 && idle,
              $sformatf("got cnt=%0d idle=%b, want cnt=2 idle=1", pop_count, idle));

        // asynchronous reset mid-transfer with two words buffered
        do_reset();
        push_word(32'h21); push_word(32'h22); push_word(32'h23);
        en = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_pre", out_valid && out_data == 32'h21 && pop_count == 4'd2 && !fifo_pop,
              $sformatf("got valid=%b data=%h cnt=%0d pop=%b, want 1 21 2 0",
                        out_valid, out_data, pop_count, fifo_pop));
        #1;
        rst = 1'b1;
        #1;
        check("rst_async", !out_valid && !fifo_pop && out_data == '0 && pop_count == '0,
              $sformatf("got valid=%b pop=%b data=%h cnt=%0d, want 0 0 0 0",
                        out_valid, fifo_pop, out_data, pop_count));
        rd_snap = rd;
        @(posedge clk);
        @(negedge clk);
        check("rst_no_pop", rd == rd_snap && !out_valid && !fifo_pop,
              $sformatf("got head=%0d valid=%b pop=%b, want head=%0d valid=0 pop=0",
                        rd, out_valid, fifo_pop, rd_snap));
        rst = 1'b0;
        out_ready = 1'b1;
        got_first = 1'b0;
        first_word = '0;
        for (int c = 0; c < 10 && !got_first; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                got_first = 1'b1;
                first_word = out_data;
            end
        end
        check("rst_resume", got_first && first_word == 32'h23,
              $sformatf("got valid=%b data=%h, want 1 23", got_first, first_word));
        $display("reset test first word after reset=%h", first_word);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_pop_ctrl.md
Name: fifo_pop_ctrl

Overview:
Read-side controller for the team's FIFO push/pop/pndng interface. It pops words from the FIFO head whenever data is pending and it has room, and presents them downstream on a valid/ready stream through a 2-entry skid buffer. It sustains one word per cycle under continuous downstream ready, without loss or duplication under backpressure. It sits between a FIFO's read port and any consumer block.

Parameters:
bits, 32, data word width (matches the FIFO bits parameter).
cnt_w, 16, width of the pop counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  pop enable; when low, no new pops are issued and buffered words still drain.
fifo_dout  input  bits  FIFO head word; valid combinationally while fifo_pndng=1.
fifo_pndng  input  1  FIFO has at least one word.
fifo_pop  output  1  pops the FIFO head on this clk edge (combinational).
out_data  output  bits  oldest buffered word.
out_valid  output  1  out_data is valid.
out_ready  input  1  consumer accepts out_data this cycle.
pop_count  output  cnt_w  total pops since reset; wraps modulo 2^cnt_w.
idle  output  1  buffer empty and fifo_pndng=0.

Behaviour:
- FIFO contract: while fifo_pndng=1, fifo_dout shows the head word. When fifo_pop=1 at a rising edge, that word is consumed, and the next head appears after the edge.
- Buffer states: S_EMPTY (0 words), S_ONE (1 word), S_TWO (2 words). Entries are e0 (head, drives out_data) and e1.
- fifo_pop = en & fifo_pndng & (state != S_TWO) & !rst. This is purely combinational and is never asserted while fifo_pndng=0.
- Let p = fifo_pop and f = out_valid & out_ready. Transitions:
  - S_EMPTY:
    - p: e0 <= fifo_dout, go to S_ONE.
    - otherwise: stay.
  - S_ONE:
    - p & f: e0 <= fifo_dout, stay.
    - p & !f: e1 <= fifo_dout, go to S_TWO.
    - !p & f: go to S_EMPTY.
    - otherwise: stay.
  - S_TWO (p=0 always):
    - f: e0 <= e1, go to S_ONE.
    - otherwise: hold.
- out_valid = (state != S_EMPTY). It is registered-derived and has no combinational path from out_ready.
- out_data = e0. It is stable while out_valid=1 & out_ready=0.
- Latency: a word popped at edge N is on out_data with out_valid=1 in the cycle after edge N (1 cycle). Throughput is 1 word/cycle when out_ready stays high.
- Ordering: strict FIFO order. Each popped word is presented exactly once.
- pop_count increments by 1 on every edge with p=1 and wraps from 2^cnt_w-1 to 0.
- idle = (state == S_EMPTY) & !fifo_pndng.
- Reset (async, any time, including mid-transfer):
  - Immediately: state S_EMPTY, out_valid=0, out_data=0, e1=0, pop_count=0, fifo_pop=0.
  - Buffered words are discarded.
  - Normal operation resumes on the first rising edge after rst deasserts.
- en falls with 2 words buffered: no pops are issued; the words drain as out_ready allows.
- out_ready high while out_valid=0: no effect.

Test Plan:
- Reset: assert rst between clock edges with 2 words buffered -> out_valid=0, fifo_pop=0, out_data=0, pop_count=0 before the next edge; no pops while rst=1.
- Stream: FIFO holds 0xA, 0xB, 0xC; en=1, out_ready=1 -> fifo_pop high for 3 consecutive cycles; out_data = 0xA, 0xB, 0xC on consecutive cycles starting 1 cycle after the first pop; pop_count=3; idle=1 afterwards.
- Backpressure: FIFO holds 5 words 0x1..0x5, out_ready=0 -> exactly 2 pops, then fifo_pop=0 and out_data holds 0x1. Raise out_ready -> 0x1..0x5 delivered in order, no duplicates, pop_count=5.
- Empty FIFO: fifo_pndng=0 for 20 cycles with en=1 -> fifo_pop never asserted, out_valid=0, idle=1.
- Enable gating: 2 words buffered, en=0, FIFO non-empty, out_ready=1 -> both words drain with no pops; en=1 -> popping resumes on the next cycle.
- Counter wrap: cnt_w=4, stream 18 words -> pop_count=2 and all 18 words delivered in order.
